// File: rtl/input_conditioner_pkg.sv
// Shared widths and timing defaults for the board input conditioner and the
// digital input peripheral that consumes its outputs.
package input_conditioner_pkg;

    localparam int SW_W   = 16;
    localparam int BTN_W  = 5;
    localparam int IPIN_W = 4;
    localparam int NUM_CH = SW_W + BTN_W + IPIN_W;

    localparam int TICK_DIV_DEFAULT     = 100_000;
    localparam int STABLE_TICKS_DEFAULT = 4;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One debounced bit: two-flop synchronizer, saturating disagreement counter
// advanced only on the shared sample tick, and the stable output flop.
module debounce_channel #(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw_in,
    output logic stable_out
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // The output only flips after STABLE_TICKS consecutive disagreeing
    // samples; any agreeing sample restarts the count.
    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (tick) begin
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_out = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces switches, buttons and external pins on a shared sample tick and
// derives per-button rising-edge pulses and sticky press flags.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw_in,
    input  logic [BTN_W-1:0]  btn_in,
    input  logic [IPIN_W-1:0] ipin_in,
    input  logic [BTN_W-1:0]  evt_clr,
    output logic [SW_W-1:0]   sw,
    output logic [BTN_W-1:0]  btn,
    output logic [IPIN_W-1:0] ipin,
    output logic [BTN_W-1:0]  btn_rise,
    output logic [BTN_W-1:0]  btn_evt
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [NUM_CH-1:0] raw_all;
    logic [NUM_CH-1:0] stable_all;
    logic [BTN_W-1:0]  btn_prev_q, btn_prev_d;
    logic [BTN_W-1:0]  btn_rise_q, btn_rise_d;
    logic [BTN_W-1:0]  btn_evt_q, btn_evt_d;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign raw_all = {ipin_in, btn_in, sw_in};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .raw_in    (raw_all[i]),
            .stable_out(stable_all[i])
        );
    end

    assign sw   = stable_all[SW_W-1:0];
    assign btn  = stable_all[SW_W +: BTN_W];
    assign ipin = stable_all[SW_W+BTN_W +: IPIN_W];

    // A new press in the same cycle as its clear keeps the flag set.
    always_comb begin
        btn_prev_d = btn;
        btn_rise_d = btn & ~btn_prev_q;
        btn_evt_d  = btn_rise_q | (btn_evt_q & ~evt_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q <= '0;
            btn_rise_q <= '0;
            btn_evt_q  <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            btn_rise_q <= btn_rise_d;
            btn_evt_q  <= btn_evt_d;
        end
    end

    assign btn_rise = btn_rise_q;
    assign btn_evt  = btn_evt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with TICK_DIV=4 and STABLE_TICKS=3.
module tb_input_conditioner;

    logic        clk;
    logic        rst;
    logic [15:0] sw_in;
    logic [4:0]  btn_in;
    logic [3:0]  ipin_in;
    logic [4:0]  evt_clr;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic [3:0]  ipin;
    logic [4:0]  btn_rise;
    logic [4:0]  btn_evt;

    int total = 0;
    int bad   = 0;

    input_conditioner #(
        .TICK_DIV    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .btn_in  (btn_in),
        .ipin_in (ipin_in),
        .evt_clr (evt_clr),
        .sw      (sw),
        .btn     (btn),
        .ipin    (ipin),
        .btn_rise(btn_rise),
        .btn_evt (btn_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] s, input logic [4:0] b,
                                 input logic [3:0] p, input logic [4:0] c);
        sw_in   = s;
        btn_in  = b;
        ipin_in = p;
        evt_clr = c;
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int  first_k;
        int  rise_cnt;
        int  fall_k;
        logic seen;
        logic any_hi;
        logic [4:0] evt_snap;

        // Reset with all switches high
        rst = 1'b1;
        applyStimulus(16'hFFFF, 5'h00, 4'h0, 5'h00);
        waitCycles(3);
        checkOutput("rst_sw", 32'(sw), 32'h0);
        checkOutput("rst_btn", 32'(btn), 32'h0);
        checkOutput("rst_ipin", 32'(ipin), 32'h0);
        checkOutput("rst_rise", 32'(btn_rise), 32'h0);
        checkOutput("rst_evt", 32'(btn_evt), 32'h0);
        rst = 1'b0;

        // Counter restarts at 0: sync at edge 2, ticks at edges 4/8/12
        first_k = 0;
        for (int k = 1; k <= 20; k++) begin
            waitCycles(1);
            if (first_k == 0 && sw == 16'hFFFF) first_k = k;
        end
        checkOutput("rel_lat_lo", 32'(first_k >= 10), 32'h1);
        checkOutput("rel_lat_hi", 32'(first_k <= 14), 32'h1);
        checkOutput("rel_lat_exact", 32'(first_k), 32'd12);

        // Glitch: btn_in[0] high for exactly 2 ticks
        any_hi = 1'b0;
        applyStimulus(16'hFFFF, 5'b00001, 4'h0, 5'h00);
        for (int k = 0; k < 8; k++) begin
            waitCycles(1);
            any_hi |= btn[0] | btn_rise[0] | btn_evt[0];
        end
        applyStimulus(16'hFFFF, 5'b00000, 4'h0, 5'h00);
        for (int k = 0; k < 30; k++) begin
            waitCycles(1);
            any_hi |= btn[0] | btn_rise[0] | btn_evt[0];
        end
        checkOutput("glitch_blocked", 32'(any_hi), 32'h0);

        // Press on btn 2
        seen = 1'b0;
        rise_cnt = 0;
        applyStimulus(16'hFFFF, 5'b00100, 4'h0, 5'h00);
        for (int k = 0; k < 40; k++) begin
            waitCycles(1);
            if (btn_rise[2]) rise_cnt++;
            if (btn[2]) seen = 1'b1;
        end
        checkOutput("press_btn", 32'(seen), 32'h1);
        checkOutput("press_rise_cnt", 32'(rise_cnt), 32'd1);
        checkOutput("press_evt", 32'(btn_evt), 32'b00100);

        // Collision: clear btn 1 in its own rise cycle
        seen = 1'b0;
        applyStimulus(16'hFFFF, 5'b00110, 4'h0, 5'h00);
        for (int k = 0; k < 40 && !seen; k++) begin
            waitCycles(1);
            if (btn_rise[1]) begin
                seen = 1'b1;
                evt_clr = 5'b00010;
            end
        end
        checkOutput("col_rise_seen", 32'(seen), 32'h1);
        waitCycles(1);
        evt_clr = 5'b00000;
        checkOutput("col_evt", 32'(btn_evt), 32'b00110);

        // Clear btn 2 only
        evt_clr = 5'b00100;
        waitCycles(1);
        evt_clr = 5'b00000;
        checkOutput("clr_evt", 32'(btn_evt), 32'b00010);
        waitCycles(20);
        checkOutput("clr_evt_stays", 32'(btn_evt), 32'b00010);
        checkOutput("clr_btn_held", 32'(btn), 32'b00110);

        // Release on btn 4
        applyStimulus(16'hFFFF, 5'b10110, 4'h0, 5'h00);
        waitCycles(30);
        checkOutput("rel4_btn_up", 32'(btn[4]), 32'h1);
        evt_snap = btn_evt;
        rise_cnt = 0;
        fall_k = 0;
        applyStimulus(16'hFFFF, 5'b00110, 4'h0, 5'h00);
        for (int k = 1; k <= 20; k++) begin
            waitCycles(1);
            if (btn_rise[4]) rise_cnt++;
            if (fall_k == 0 && !btn[4]) fall_k = k;
        end
        checkOutput("rel4_lat_lo", 32'(fall_k >= 10), 32'h1);
        checkOutput("rel4_lat_hi", 32'(fall_k <= 14), 32'h1);
        checkOutput("rel4_no_rise", 32'(rise_cnt), 32'd0);
        checkOutput("rel4_evt", 32'(btn_evt), 32'(evt_snap));

        // Mid-count reset on ipin
        applyStimulus(16'hFFFF, 5'b00110, 4'b1010, 5'h00);
        waitCycles(8);
        rst = 1'b1;
        waitCycles(2);
        checkOutput("mid_rst_btn", 32'(btn), 32'h0);
        checkOutput("mid_rst_evt", 32'(btn_evt), 32'h0);
        checkOutput("mid_rst_sw", 32'(sw), 32'h0);
        applyStimulus(16'hFFFF, 5'b00110, 4'b0000, 5'h00);
        rst = 1'b0;
        any_hi = 1'b0;
        rise_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            waitCycles(1);
            if (ipin != 4'h0) any_hi = 1'b1;
            if (btn_rise[2]) rise_cnt++;
        end
        checkOutput("mid_ipin_zero", 32'(any_hi), 32'h0);
        checkOutput("held_rise_once", 32'(rise_cnt), 32'd1);
        checkOutput("held_evt", 32'(btn_evt), 32'b00110);
        checkOutput("held_sw", 32'(sw), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
